// File: rtl/pipe_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_queue
//  Description : Parametrised inter-stage payload buffer. Holds up to DEPTH
//                WIDTH-bit payloads between two pipeline stages using a
//                valid/ready handshake on both sides. A synchronous flush
//                kills every held entry (branch/jump/trap redirect).
//  Parameters  : WIDTH - payload width in bits
//                DEPTH - number of entries (>= 1, any integer)
//                CNT_W - occupancy counter width (derived, do not override)
//  Ports       : clk      - rising-edge clock
//                resetN   - asynchronous active-low reset
//                flush    - synchronous kill of all entries
//                inValid  - upstream payload valid
//                inReady  - queue can accept a payload this cycle
//                inData   - upstream payload
//                outValid - head entry valid
//                outReady - downstream consumes head this cycle
//                outData  - head payload
//                count    - current occupancy, 0..DEPTH
//  Options     : PIPE_QUEUE_BYPASS_EN - when defined, an empty queue forwards
//                inValid/inData combinationally to outValid/outData.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_queue #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;   // payload is written into storage
    logic w_pop;    // stored head entry is consumed

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);
    assign inReady = ~w_full;
    assign count   = r_count;

`ifdef PIPE_QUEUE_BYPASS_EN
    logic w_bypass_take;

    // Empty queue: payload goes straight through. If it is consumed in the
    // same cycle it never touches storage and occupancy stays zero.
    assign w_bypass_take = w_empty & ~flush & inValid & outReady;
    assign outValid      = w_empty ? (inValid & ~flush) : 1'b1;
    assign outData       = w_empty ? inData : r_mem[r_head];
    assign w_push        = inValid & ~w_full & ~flush & ~w_bypass_take;
    assign w_pop         = ~w_empty & outReady & ~flush;
`else
    assign outValid = ~w_empty;
    assign outData  = r_mem[r_head];
    assign w_push   = inValid & ~w_full & ~flush;
    assign w_pop    = ~w_empty & outReady & ~flush;
`endif

    // Storage is deliberately not reset; contents are only observed while
    // the corresponding entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= inData;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= f_next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= f_next_ptr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_queue
//  Description : Directed self-checking bench for pipe_queue. Main instance
//                is WIDTH=32/DEPTH=2; a second DEPTH=3 instance covers
//                non-power-of-two pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_queue;

    localparam int WIDTH = 32;

    logic             clk;
    logic             resetN;
    logic             flush;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] outData;
    logic [1:0]       count;

    logic             q3_inValid;
    logic             q3_inReady;
    logic [WIDTH-1:0] q3_inData;
    logic             q3_outValid;
    logic             q3_outReady;
    logic [WIDTH-1:0] q3_outData;
    logic [1:0]       q3_count;

    int n_checks;
    int n_fail;

    pipe_queue #(.WIDTH(WIDTH), .DEPTH(2)) u_dut (
        .clk      (clk),
        .resetN   (resetN),
        .flush    (flush),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .count    (count)
    );

    pipe_queue #(.WIDTH(WIDTH), .DEPTH(3)) u_dut3 (
        .clk      (clk),
        .resetN   (resetN),
        .flush    (1'b0),
        .inValid  (q3_inValid),
        .inReady  (q3_inReady),
        .inData   (q3_inData),
        .outValid (q3_outValid),
        .outReady (q3_outReady),
        .outData  (q3_outData),
        .count    (q3_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        resetN      = 1'b0;
        flush       = 1'b0;
        inValid     = 1'b0;
        inData      = '0;
        outReady    = 1'b0;
        q3_inValid  = 1'b0;
        q3_inData   = '0;
        q3_outReady = 1'b0;

        // 1. Reset and fill
        tick();
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_inReady",  64'(inReady),  64'd1);
        resetN = 1'b1;
        tick();
        inValid = 1'b1; inData = 32'hA;
        tick();
        chk("fill1_count",    64'(count),    64'd1);
        chk("fill1_outValid", 64'(outValid), 64'd1);
        chk("fill1_outData",  64'(outData),  64'hA);
        inData = 32'hB;
        tick();
        inValid = 1'b0;
        chk("fill2_count",   64'(count),   64'd2);
        chk("fill2_inReady", 64'(inReady), 64'd0);
        chk("fill2_outData", 64'(outData), 64'hA);
        // push attempt while full is ignored
        inValid = 1'b1; inData = 32'hEE;
        tick();
        inValid = 1'b0;
        chk("full_ignore_count", 64'(count), 64'd2);

        // 2. Drain in order
        outReady = 1'b1;
        chk("drain0_outData", 64'(outData), 64'hA);
        tick();
        chk("drain1_count",   64'(count),   64'd1);
        chk("drain1_inReady", 64'(inReady), 64'd1);
        chk("drain1_outData", 64'(outData), 64'hB);
        tick();
        chk("drain2_count",    64'(count),    64'd0);
        chk("drain2_outValid", 64'(outValid), 64'd0);
        // pop on empty is ignored
        tick();
        chk("empty_pop_count", 64'(count), 64'd0);
        outReady = 1'b0;

        // 3. Simultaneous push/pop with pointer wrap
        inValid = 1'b1; inData = 32'h1;
        tick();
        for (int i = 0; i < 5; i++) begin
            inData   = 32'(i + 2);
            outReady = 1'b1;
            chk("pp_head_before", 64'(outData), 64'(i + 1));
            tick();
            chk("pp_count",   64'(count),   64'd1);
            chk("pp_outData", 64'(outData), 64'(i + 2));
        end
        inValid = 1'b0;
        tick();
        chk("pp_drain_count", 64'(count), 64'd0);
        outReady = 1'b0;

        // 4. Flush priority
        inValid = 1'b1; inData = 32'h3;
        tick();
        inData = 32'h4;
        tick();
        chk("fl_pre_count", 64'(count), 64'd2);
        flush = 1'b1; inValid = 1'b1; inData = 32'hF; outReady = 1'b1;
        #1;
        chk("fl_cycle_outValid", 64'(outValid), 64'd1);
        chk("fl_cycle_outData",  64'(outData),  64'h3);
        tick();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        chk("fl_count",    64'(count),    64'd0);
        chk("fl_outValid", 64'(outValid), 64'd0);
        chk("fl_inReady",  64'(inReady),  64'd1);
        inValid = 1'b1; inData = 32'h5;
        tick();
        inValid = 1'b0;
        chk("fl_after_outData", 64'(outData), 64'h5);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("fl_after_count", 64'(count), 64'd0);

        // 5. Async reset mid-stream
        inValid = 1'b1; inData = 32'h6;
        tick();
        inValid = 1'b0;
        chk("ar_pre_count", 64'(count), 64'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk("ar_outValid", 64'(outValid), 64'd0);
        chk("ar_count",    64'(count),    64'd0);
        #1;
        resetN = 1'b1;
        tick();
        inValid = 1'b1; inData = 32'h7;
        tick();
        inValid = 1'b0;
        chk("ar_next_outData", 64'(outData), 64'h7);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("ar_drain_count", 64'(count), 64'd0);

        // 6. Bypass behaviour on an empty queue
        inValid = 1'b1; inData = 32'hC; outReady = 1'b1;
        #1;
`ifdef PIPE_QUEUE_BYPASS_EN
        chk("bp_outValid", 64'(outValid), 64'd1);
        chk("bp_outData",  64'(outData),  64'hC);
        tick();
        inValid = 1'b0; outReady = 1'b0;
        chk("bp_count", 64'(count), 64'd0);
`else
        chk("nbp_outValid", 64'(outValid), 64'd0);
        outReady = 1'b0;
        tick();
        inValid = 1'b0;
        chk("nbp_count",    64'(count),    64'd1);
        chk("nbp_outValid1", 64'(outValid), 64'd1);
        chk("nbp_outData",  64'(outData),  64'hC);
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        chk("nbp_drain_count", 64'(count), 64'd0);
`endif

        // DEPTH=3 instance: fill, pop one, push across the wrap, drain
        q3_inValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q3_inData = 32'(16 + i);
            tick();
        end
        q3_inValid = 1'b0;
        chk("q3_full_count",   64'(q3_count),   64'd3);
        chk("q3_full_inReady", 64'(q3_inReady), 64'd0);
        q3_outReady = 1'b1;
        tick();
        q3_outReady = 1'b0;
        chk("q3_pop_outData", 64'(q3_outData), 64'd17);
        q3_inValid = 1'b1; q3_inData = 32'd19;
        tick();
        q3_inValid = 1'b0;
        chk("q3_wrap_count", 64'(q3_count), 64'd3);
        q3_outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("q3_drain_data", 64'(q3_outData), 64'(17 + i));
            tick();
        end
        q3_outReady = 1'b0;
        chk("q3_drain_count",    64'(q3_count),    64'd0);
        chk("q3_drain_outValid", 64'(q3_outValid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
